// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one req/ack memory bus between instruction fetch and load/store.
// Optional ack timeout (wait counter, err_o) is built when MEM_ARB_TIMEOUT_EN is defined.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_done_o,
  input  logic                mem_req_i,
  input  logic                mem_we_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  input  logic [DATA_W/8-1:0] mem_sel_i,
  output logic [DATA_W-1:0]   mem_rdata_o,
  output logic                mem_done_o,
  output logic                bus_req_o,
  output logic                bus_we_o,
  output logic [ADDR_W-1:0]   bus_addr_o,
  output logic [DATA_W-1:0]   bus_wdata_o,
  output logic [DATA_W/8-1:0] bus_sel_o,
  input  logic                bus_ack_i,
  input  logic [DATA_W-1:0]   bus_rdata_i,
  output logic                err_o,
  output logic                stall_req_o
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GNT_MEM = 2'd1;
  localparam logic [1:0] GNT_IF  = 2'd2;

  logic [1:0] state_r;
  logic       if_pend_s;
  logic       mem_pend_s;
  logic       expire_s;

  // A port whose done pulse is showing is masked, so it cannot re-win in its own done cycle.
  assign if_pend_s   = if_req_i & ~if_done_o;
  assign mem_pend_s  = mem_req_i & ~mem_done_o;
  assign stall_req_o = if_pend_s | mem_pend_s;

  // TIMEOUT below 1 is not a legal configuration.
  if (TIMEOUT < 1) begin : g_timeout_illegal
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CNT_W-1:0] wait_cnt_r;

  // Expiry is the TIMEOUT-th granted cycle without ack; an ack on that edge still wins.
  assign expire_s = (wait_cnt_r == CNT_W'(TIMEOUT - 1));

  // Wait counter: zero while idle (so it is clear at grant), counts granted cycles without ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_r <= '0;
    end else if (state_r == IDLE) begin
      wait_cnt_r <= '0;
    end else if (bus_ack_i) begin
      wait_cnt_r <= '0;
    end else begin
      wait_cnt_r <= wait_cnt_r + CNT_W'(1);
    end
  end
`else
  assign expire_s = 1'b0;
`endif

  // Arbitration, bus sequencing and completion reporting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      bus_sel_o   <= '0;
      if_rdata_o  <= '0;
      if_done_o   <= 1'b0;
      mem_rdata_o <= '0;
      mem_done_o  <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      if_done_o  <= 1'b0;
      mem_done_o <= 1'b0;
      err_o      <= 1'b0;
      case (state_r)
        IDLE: begin
          if (mem_pend_s) begin
            state_r     <= GNT_MEM;
            bus_req_o   <= 1'b1;
            bus_we_o    <= mem_we_i;
            bus_addr_o  <= mem_addr_i;
            bus_wdata_o <= mem_wdata_i;
            bus_sel_o   <= mem_sel_i;
          end else if (if_pend_s) begin
            state_r     <= GNT_IF;
            bus_req_o   <= 1'b1;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= if_addr_i;
            bus_wdata_o <= '0;
            bus_sel_o   <= '1;
          end else begin
            state_r   <= IDLE;
            bus_req_o <= 1'b0;
          end
        end
        GNT_MEM: begin
          if (bus_ack_i) begin
            if (!bus_we_o) begin
              mem_rdata_o <= bus_rdata_i;
            end
            bus_req_o  <= 1'b0;
            mem_done_o <= 1'b1;
            state_r    <= IDLE;
          end else if (expire_s) begin
            mem_rdata_o <= '0;
            bus_req_o   <= 1'b0;
            mem_done_o  <= 1'b1;
            err_o       <= 1'b1;
            state_r     <= IDLE;
          end else begin
            state_r <= GNT_MEM;
          end
        end
        GNT_IF: begin
          if (bus_ack_i) begin
            if_rdata_o <= bus_rdata_i;
            bus_req_o  <= 1'b0;
            if_done_o  <= 1'b1;
            state_r    <= IDLE;
          end else if (expire_s) begin
            if_rdata_o <= '0;
            bus_req_o  <= 1'b0;
            if_done_o  <= 1'b1;
            err_o      <= 1'b1;
            state_r    <= IDLE;
          end else begin
            state_r <= GNT_IF;
          end
        end
        default: begin
          state_r   <= IDLE;
          bus_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed vectors, corner sequences and a random
// run against a transaction-level reference model. Define MEM_ARB_TIMEOUT_EN to cover timeout.
module tb_mem_bus_arbiter;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TMO    = 4;
  localparam bit TMO_EN = 1'b1;
`else
  localparam int TMO    = 255;
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, mem_req, mem_we, bus_ack;
  logic [31:0] if_addr, mem_addr, mem_wdata, bus_rdata;
  logic [3:0]  mem_sel;
  logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_sel;
  logic        if_done, mem_done, bus_req, bus_we, err, stall;

  int n_cmp = 0;
  int n_bad = 0;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_done_o(if_done),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
    .mem_sel_i(mem_sel), .mem_rdata_o(mem_rdata), .mem_done_o(mem_done),
    .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata),
    .bus_sel_o(bus_sel), .bus_ack_i(bus_ack), .bus_rdata_i(bus_rdata),
    .err_o(err), .stall_req_o(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_mem;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    int          waits;
    logic [31:0] rdata;
    int          lat;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_sel;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    bit seen;
    tick();
    if (v.is_mem) begin
      mem_req = 1'b1; mem_we = v.we; mem_addr = v.addr; mem_wdata = v.wdata; mem_sel = v.sel;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    bus_ack   = 1'b1;             // ack while idle must be ignored
    bus_rdata = 32'hBAD0_0000;
    #1;
    chk("v_stall_c0", stall, 1);
    chk("v_busreq_c0", bus_req, 0);
    seen = 1'b0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      tick();
      bus_ack   = (c == 1 + v.waits);
      bus_rdata = v.rdata;
      #1;
      if (v.is_mem ? mem_done : if_done) begin
        seen = 1'b1;
        chk("v_latency", c, v.lat);
        chk("v_rdata", v.is_mem ? mem_rdata : if_rdata, v.exp_rdata);
        chk("v_err", err, 0);
        chk("v_busreq_done", bus_req, 0);
        chk("v_stall_done", stall, 0);
      end else begin
        chk("v_busreq", bus_req, 1);
        chk("v_addr", bus_addr, v.addr);
        chk("v_we", bus_we, v.is_mem & v.we);
        chk("v_sel", bus_sel, v.exp_sel);
        if (v.we) chk("v_wdata", bus_wdata, v.wdata);
        chk("v_stall", stall, 1);
      end
    end
    if (!seen) chk("v_done_seen", 0, 1);
    tick();
    mem_req = 1'b0; if_req = 1'b0; bus_ack = 1'b0;
  endtask

  // reference model state (transaction level)
  bit          busy, port_mem, m_hold, i_hold;
  int          waited;
  logic        e_bus_req, e_we, e_if_done, e_mem_done, e_err;
  logic [31:0] e_addr, e_wdata, e_if_rdata, e_mem_rdata;
  logic [3:0]  e_sel;

  task automatic model_step();
    logic n_if_done, n_mem_done, n_err;
    n_if_done = 1'b0; n_mem_done = 1'b0; n_err = 1'b0;
    if (!busy) begin
      if (mem_req && !e_mem_done) begin
        busy = 1'b1; port_mem = 1'b1; waited = 0;
        e_we = mem_we; e_addr = mem_addr; e_wdata = mem_wdata; e_sel = mem_sel;
      end else if (if_req && !e_if_done) begin
        busy = 1'b1; port_mem = 1'b0; waited = 0;
        e_we = 1'b0; e_addr = if_addr; e_sel = 4'hF;
      end
    end else if (bus_ack) begin
      busy = 1'b0;
      if (port_mem) begin
        n_mem_done = 1'b1;
        if (!e_we) e_mem_rdata = bus_rdata;
      end else begin
        n_if_done = 1'b1;
        e_if_rdata = bus_rdata;
      end
    end else begin
      waited++;
      if (TMO_EN && waited >= TMO) begin
        busy = 1'b0; n_err = 1'b1;
        if (port_mem) begin n_mem_done = 1'b1; e_mem_rdata = 32'h0; end
        else begin n_if_done = 1'b1; e_if_rdata = 32'h0; end
      end
    end
    e_if_done = n_if_done; e_mem_done = n_mem_done; e_err = n_err; e_bus_req = busy;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, expected finish before 1000000 ns");
    $fatal(1);
  end

  initial begin
    int md, idn, hi;
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 0, 32'h3401_1100, 2, 32'h3401_1100, 4'hF};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0080, 32'h0, 4'hF, 1, 32'h1122_3344, 3, 32'h1122_3344, 4'hF};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 4'b0011, 3, 32'h5555_5555, 5, 32'h1122_3344, 4'b0011};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0, 4'h0, 2, 32'h0000_0013, 4, 32'h0000_0013, 4'hF};
    vecs[4] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'b1000, 0, 32'hA5A5_A5A5, 2, 32'hA5A5_A5A5, 4'b1000};

    rst = 1'b0; if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0; bus_ack = 1'b0;
    if_addr = 32'h0; mem_addr = 32'h0; mem_wdata = 32'h0; mem_sel = 4'h0; bus_rdata = 32'h0;
    tick(); tick();
    chk("rst_busreq", bus_req, 0);
    chk("rst_buswe", bus_we, 0);
    chk("rst_busaddr", bus_addr, 0);
    chk("rst_dones", {if_done, mem_done}, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", {if_rdata, mem_rdata}, 0);
    chk("rst_stall", stall, 0);
    rst = 1'b1;

    // reset in the middle of a granted load
    tick(); mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_0040; mem_sel = 4'hF;
    tick(); #1;
    chk("rst_mid_pre_busreq", bus_req, 1);
    rst = 1'b0; #1;
    chk("rst_mid_busreq", bus_req, 0);
    chk("rst_mid_dones", {if_done, mem_done}, 0);
    chk("rst_mid_err", err, 0);
    tick();
    chk("rst_hold_busreq", bus_req, 0);
    mem_req = 1'b0; #2; rst = 1'b1;
    tick();
    chk("rst_after_busreq", bus_req, 0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // contention: MEM first, IF granted in MEM done cycle
    tick();
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_0080; mem_sel = 4'hF;
    if_req = 1'b1; if_addr = 32'h0000_0104; bus_ack = 1'b0;
    md = -1; idn = -1; hi = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (md >= 0 && c > md) mem_req = 1'b0;
      if (idn >= 0 && c > idn) if_req = 1'b0;
      if (mem_done && md < 0) md = c;
      if (if_done && idn < 0) idn = c;
      hi = bus_req ? hi + 1 : 0;
      bus_ack = bus_req && (hi == 2);
      bus_rdata = 32'hC0DE_0000 + c;
      #1;
      if (c == 1) chk("cont_first_addr", bus_addr, 32'h80);
      if (c == 3) chk("cont_stall_c3", stall, 1);
      if (c == 4) begin
        chk("cont_if_addr", bus_addr, 32'h104);
        chk("cont_if_sel", bus_sel, 4'hF);
        chk("cont_if_we", bus_we, 0);
      end
    end
    chk("cont_mem_done_cyc", md, 3);
    chk("cont_if_done_cyc", idn, 6);
    chk("cont_mem_rdata", mem_rdata, 32'hC0DE_0002);
    chk("cont_if_rdata", if_rdata, 32'hC0DE_0005);
    bus_ack = 1'b0;

    // mask: load held high through its done cycle is not re-granted
    tick(); mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_0040; mem_sel = 4'hF;
    tick(); bus_ack = 1'b1; bus_rdata = 32'h0BAD_F00D;
    tick(); bus_ack = 1'b0; #1;
    chk("mask_done", mem_done, 1);
    chk("mask_stall", stall, 0);
    tick(); mem_addr = 32'h0000_0044; #1;
    chk("mask_no_regrant", bus_req, 0);
    chk("mask_rdata", mem_rdata, 32'h0BAD_F00D);
    tick(); #1;
    chk("mask_new_grant", bus_req, 1);
    chk("mask_new_addr", bus_addr, 32'h44);
    bus_ack = 1'b1; bus_rdata = 32'h0000_0044;
    tick(); bus_ack = 1'b0; #1;
    chk("mask_new_done", mem_done, 1);
    tick(); mem_req = 1'b0;

    // fetch with no ack
    tick(); if_req = 1'b1; if_addr = 32'h0000_0200; bus_ack = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk("to_busreq_wait", bus_req, 1);
      chk("to_no_done", if_done, 0);
    end
    tick(); #1;
    chk("to_busreq_drop", bus_req, 0);
    chk("to_done", if_done, 1);
    chk("to_err", err, 1);
    chk("to_rdata", if_rdata, 0);
    chk("to_stall", stall, 0);
    tick(); if_req = 1'b0; #1;
    chk("to_err_pulse", err, 0);
`else
    repeat (300) tick();
    #1;
    chk("noto_busreq", bus_req, 1);
    chk("noto_done", if_done, 0);
    chk("noto_err", err, 0);
    chk("noto_stall", stall, 1);
    bus_ack = 1'b1; bus_rdata = 32'h0000_0073;
    tick(); bus_ack = 1'b0; #1;
    chk("noto_late_done", if_done, 1);
    chk("noto_late_rdata", if_rdata, 32'h73);
    chk("noto_late_err", err, 0);
    tick(); if_req = 1'b0;
`endif
    run_vec(vecs[0]);

    // random traffic against the reference model
    rst = 1'b0; tick(); rst = 1'b1;
    busy = 1'b0; port_mem = 1'b0; m_hold = 1'b0; i_hold = 1'b0; waited = 0;
    e_bus_req = 1'b0; e_we = 1'b0; e_if_done = 1'b0; e_mem_done = 1'b0; e_err = 1'b0;
    e_addr = 32'h0; e_wdata = 32'h0; e_sel = 4'h0; e_if_rdata = 32'h0; e_mem_rdata = 32'h0;
    for (int n = 0; n < 3000; n++) begin
      tick();
      if (m_hold) begin
        mem_req = 1'b0; m_hold = 1'b0;
      end else if (mem_req && e_mem_done) begin
        if ($urandom_range(1, 0) == 1) m_hold = 1'b1;
        else mem_req = 1'b0;
      end else if (!mem_req && $urandom_range(2, 0) == 0) begin
        mem_req = 1'b1; mem_we = 1'($urandom); mem_addr = $urandom;
        mem_wdata = $urandom; mem_sel = 4'($urandom);
      end
      if (i_hold) begin
        if_req = 1'b0; i_hold = 1'b0;
      end else if (if_req && e_if_done) begin
        if ($urandom_range(1, 0) == 1) i_hold = 1'b1;
        else if_req = 1'b0;
      end else if (!if_req && $urandom_range(2, 0) == 0) begin
        if_req = 1'b1; if_addr = $urandom;
      end
      bus_ack   = ($urandom_range(2, 0) == 0);
      bus_rdata = $urandom;
      #1;
      chk("rnd_busreq", bus_req, e_bus_req);
      if (e_bus_req) begin
        chk("rnd_we", bus_we, e_we);
        chk("rnd_addr", bus_addr, e_addr);
        chk("rnd_sel", bus_sel, e_sel);
        if (e_we) chk("rnd_wdata", bus_wdata, e_wdata);
      end
      chk("rnd_if_done", if_done, e_if_done);
      chk("rnd_mem_done", mem_done, e_mem_done);
      chk("rnd_err", err, e_err);
      chk("rnd_if_rdata", if_rdata, e_if_rdata);
      chk("rnd_mem_rdata", mem_rdata, e_mem_rdata);
      chk("rnd_stall", stall, (if_req & ~e_if_done) | (mem_req & ~e_mem_done));
      model_step();
    end
    mem_req = 1'b0; if_req = 1'b0; bus_ack = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
